// File: rtl/store_sequencer_pkg.sv
// Shared types and encodings for the store-size sequencer: state enum,
// store-type codes and merge-mux select codes.
package store_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WRITE   = 3'd3,
      FINISH  = 3'd4
   } state_e;

   localparam logic [1:0] ST_SW  = 2'b00;
   localparam logic [1:0] ST_SH  = 2'b01;
   localparam logic [1:0] ST_SB  = 2'b10;
   localparam logic [1:0] ST_ILL = 2'b11;

   localparam logic [1:0] SS_WORD = 2'b00;
   localparam logic [1:0] SS_HALF = 2'b01;
   localparam logic [1:0] SS_BYTE = 2'b10;

   // Wide enough for the largest read latency (7).
   localparam int CNT_W = 3;

   function automatic logic [1:0] size_sel(input logic [1:0] st);
      logic [1:0] sel;
      sel = SS_WORD;
      case (st)
         ST_SH:   sel = SS_HALF;
         ST_SB:   sel = SS_BYTE;
         default: sel = SS_WORD;
      endcase
      return sel;
   endfunction

   function automatic logic misaligned(input logic [1:0] st, input logic [1:0] a_lo);
      return ((st == ST_SW) && (a_lo != 2'b00)) || ((st == ST_SH) && a_lo[0]);
   endfunction

endpackage

// File: rtl/store_sequencer.sv
// Multicycle sequencer for sw/sh/sb stores: direct write for sw, read-modify-write
// for sh/sb. Define STORE_ALIGN_CHECK_EN to reject misaligned sw/sh stores.
//
// state   | meaning
// IDLE    | waiting for start; latches addr and store type on accept
// RD_REQ  | one-cycle mem_rd strobe, loads wait counter
// RD_WAIT | counts down read latency, captures mem_rdata at zero
// WRITE   | one-cycle mem_wr strobe with merge select driven
// FINISH  | one-cycle done (and err if flagged)
module store_sequencer
   import store_pkg::*;
#(
   parameter int MEM_RD_LAT = 1,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        store_type,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [1:0]        store_size_ctrl,
   output logic [31:0]       merge_word,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_RD_LAT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        type_q, type_d;
   logic              err_q, err_d;
   logic [31:0]       merge_word_q, merge_word_d;
   logic              reject;

`ifdef STORE_ALIGN_CHECK_EN
   assign reject = (store_type == ST_ILL) || misaligned(store_type, addr[1:0]);
`else
   assign reject = (store_type == ST_ILL);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         type_q       <= ST_SW;
         err_q        <= 1'b0;
         merge_word_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         type_q       <= type_d;
         err_q        <= err_d;
         merge_word_q <= merge_word_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      type_d       = type_q;
      err_d        = err_q;
      merge_word_d = merge_word_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d = addr;
               type_d = store_type;
               err_d  = reject;
               if (reject)
                  state_d = FINISH;
               else if (store_type == ST_SW)
                  state_d = WRITE;
               else
                  state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            cnt_d   = WAIT_INIT;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               merge_word_d = mem_rdata;
               state_d      = WRITE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WRITE:   state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All strobes decode only the state register, so they cannot glitch on inputs.
   assign mem_rd          = (state_q == RD_REQ);
   assign mem_wr          = (state_q == WRITE);
   assign done            = (state_q == FINISH);
   assign err             = (state_q == FINISH) && err_q;
   assign busy            = (state_q != IDLE);
   assign store_size_ctrl = ((state_q == RD_REQ) || (state_q == RD_WAIT) || (state_q == WRITE))
                            ? size_sel(type_q) : SS_WORD;
   assign mem_addr        = addr_q;
   assign merge_word      = merge_word_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Self-checking bench for store_sequencer: two instances (read latency 1 and 3),
// scoreboard of expected completions popped on each done pulse.
module tb_store_sequencer;
   import store_pkg::*;

   typedef struct {
      int          dut;
      logic        err;
      logic [31:0] mw;
      logic [1:0]  sz;
      logic [31:0] addr;
      int          lat;
      int          n_rd;
      int          n_wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  start;
   logic [1:0]  store_type;
   logic [31:0] addr;
   logic [31:0] mem_rdata;
   bit          ramp;
   logic [31:0] rd_fixed;

   logic [31:0] mem_addr_w [2];
   logic        mem_rd_w   [2];
   logic        mem_wr_w   [2];
   logic [1:0]  size_w     [2];
   logic [31:0] mw_w       [2];
   logic        busy_w     [2];
   logic        done_w     [2];
   logic        err_w      [2];

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb_q[$];
   int          lat_of [2] = '{1, 3};
   logic [31:0] exp_mw [2] = '{32'h0, 32'h0};
   int          acc_cyc[2] = '{0, 0};
   int          n_rd   [2] = '{0, 0};
   int          n_wr   [2] = '{0, 0};
   int          tot_rd [2] = '{0, 0};
   int          tot_wr [2] = '{0, 0};
   int          n_done [2] = '{0, 0};
   logic        bprev  [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rd_val(input int k);
      return 32'hC0DE_0000 | (32'(k) & 32'h0000_FFFF);
   endfunction

   assign mem_rdata = ramp ? rd_val(cyc) : rd_fixed;

   store_sequencer #(.MEM_RD_LAT(1), .ADDR_W(32)) u_lat1 (
      .clk(clk), .reset_n(reset_n), .start(start[0]), .store_type(store_type),
      .addr(addr), .mem_rdata(mem_rdata), .mem_addr(mem_addr_w[0]),
      .mem_rd(mem_rd_w[0]), .mem_wr(mem_wr_w[0]), .store_size_ctrl(size_w[0]),
      .merge_word(mw_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
   );

   store_sequencer #(.MEM_RD_LAT(3), .ADDR_W(32)) u_lat3 (
      .clk(clk), .reset_n(reset_n), .start(start[1]), .store_type(store_type),
      .addr(addr), .mem_rdata(mem_rdata), .mem_addr(mem_addr_w[1]),
      .mem_rd(mem_rd_w[1]), .mem_wr(mem_wr_w[1]), .store_size_ctrl(size_w[1]),
      .merge_word(mw_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Expected completion, computed at the cycle start is driven (accept edge ends cycle c0).
   task automatic push_exp(input int d, input logic [1:0] t, input logic [31:0] a, input int c0);
      exp_t e;
      logic rej;
      rej = (t == 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
      if ((t == 2'b00 && a[1:0] != 2'b00) || (t == 2'b01 && a[0])) rej = 1'b1;
`endif
      e.dut  = d;
      e.addr = a;
      e.err  = rej;
      e.sz   = (t == 2'b01) ? 2'b01 : (t == 2'b10) ? 2'b10 : 2'b00;
      if (rej) begin
         e.lat = 1; e.n_rd = 0; e.n_wr = 0;
      end else if (t == 2'b00) begin
         e.lat = 2; e.n_rd = 0; e.n_wr = 1;
      end else begin
         e.lat = lat_of[d] + 3; e.n_rd = 1; e.n_wr = 1;
         exp_mw[d] = ramp ? rd_val(c0 + 1 + lat_of[d]) : rd_fixed;
      end
      e.mw = exp_mw[d];
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         if (busy_w[i] && !bprev[i]) begin
            acc_cyc[i] = cyc; n_rd[i] = 0; n_wr[i] = 0;
         end
         bprev[i] = busy_w[i];
         if (mem_rd_w[i] || mem_wr_w[i])
            chk("strobe_exclusive", {31'b0, mem_rd_w[i] & mem_wr_w[i]}, 32'h0);
         if (mem_rd_w[i]) begin
            n_rd[i]++; tot_rd[i]++;
            if (sb_q.size() > 0) chk("size_at_rd", {30'b0, size_w[i]}, {30'b0, sb_q[0].sz});
         end
         if (mem_wr_w[i]) begin
            n_wr[i]++; tot_wr[i]++;
            if (sb_q.size() > 0) chk("size_at_wr", {30'b0, size_w[i]}, {30'b0, sb_q[0].sz});
         end
         if (done_w[i]) begin
            n_done[i]++;
            chk("done_expected", 32'(sb_q.size() > 0), 32'h1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               chk("done_dut", 32'(i), 32'(e.dut));
               chk("err", {31'b0, err_w[i]}, {31'b0, e.err});
               chk("merge_word", mw_w[i], e.mw);
               chk("mem_addr", mem_addr_w[i], e.addr);
               chk("latency", 32'(cyc - acc_cyc[i] + 1), 32'(e.lat));
               chk("rd_count", 32'(n_rd[i]), 32'(e.n_rd));
               chk("wr_count", 32'(n_wr[i]), 32'(e.n_wr));
            end
         end
      end
   end

   task automatic check_rst(input int d);
      chk("rst_ctrl", {25'b0, mem_rd_w[d], mem_wr_w[d], busy_w[d], done_w[d], err_w[d], size_w[d]}, 32'h0);
      chk("rst_addr", mem_addr_w[d], 32'h0);
      chk("rst_merge_word", mw_w[d], 32'h0);
   endtask

   task automatic issue(input int d, input logic [1:0] t, input logic [31:0] a);
      @(posedge clk); #1;
      store_type = t; addr = a; start[d] = 1'b1;
      push_exp(d, t, a, cyc);
      @(posedge clk); #1;
      start[d] = 1'b0; store_type = 2'b11; addr = 32'hFFFF_FFFF;
   endtask

   task automatic wait_drain(input int d);
      int k;
      k = 0;
      while ((sb_q.size() != 0 || busy_w[d]) && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_timeout", 32'(k < 40), 32'h1);
   endtask

   initial begin
      int wr0, d0, r0, w0;
      #100000;
      $display("FAIL global_timeout: observed timeout expected finish");
      $fatal(1, "bench time limit reached");
   end

   initial begin
      int wr0, d0, r0, w0;
      reset_n = 1'b0; start = 2'b00; store_type = 2'b00; addr = '0;
      ramp = 1'b0; rd_fixed = 32'h0;
      #12;
      check_rst(0); check_rst(1);
      reset_n = 1'b1;

      // Reset asserted in RD_WAIT of an sb on the latency-3 instance.
      @(posedge clk); #1;
      store_type = 2'b10; addr = 32'h50; start[1] = 1'b1;
      @(posedge clk); #1;
      start[1] = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_busy", {31'b0, busy_w[1]}, 32'h1);
      wr0 = tot_wr[1];
      reset_n = 1'b0;
      #1;
      check_rst(0); check_rst(1);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      exp_mw[0] = 32'h0; exp_mw[1] = 32'h0;
      repeat (6) @(posedge clk);
      #1;
      chk("no_wr_after_rst", 32'(tot_wr[1]), 32'(wr0));
      check_rst(1);

      // sw, then sh with a fixed read word, then sw that must leave merge_word alone.
      issue(0, 2'b00, 32'h40);        wait_drain(0);
      rd_fixed = 32'hDEAD_BEEF;
      issue(0, 2'b01, 32'h44);        wait_drain(0);
      chk("sh_merge_word", mw_w[0], 32'hDEAD_BEEF);
      rd_fixed = 32'h1234_5678;
      issue(0, 2'b00, 32'h48);        wait_drain(0);
      chk("sw_keeps_merge_word", mw_w[0], 32'hDEAD_BEEF);

      // Latency-3 instance with a cycle-stamped read word to pin capture timing.
      ramp = 1'b1;
      issue(1, 2'b10, 32'h53);        wait_drain(1);
      issue(1, 2'b01, 32'h62);        wait_drain(1);
      issue(1, 2'b00, 32'h64);        wait_drain(1);
      ramp = 1'b0;

      // Illegal store type.
      r0 = tot_rd[0]; w0 = tot_wr[0];
      issue(0, 2'b11, 32'h70);        wait_drain(0);
      chk("ill_no_access", 32'(tot_rd[0] - r0 + tot_wr[0] - w0), 32'h0);

      // start held through an sh; only a start in the IDLE cycle after FINISH is taken.
      rd_fixed = 32'hA5A5_5A5A;
      d0 = n_done[0]; r0 = tot_rd[0]; w0 = tot_wr[0];
      @(posedge clk); #1;
      store_type = 2'b01; addr = 32'h84; start[0] = 1'b1;
      push_exp(0, 2'b01, 32'h84, cyc);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         store_type = 2'b10; addr = 32'h91;
         if (k == 5) push_exp(0, 2'b10, 32'h91, cyc);
      end
      @(posedge clk); #1;
      start[0] = 1'b0;
      wait_drain(0);
      chk("busy_done_count", 32'(n_done[0] - d0), 32'h2);
      chk("busy_rd_count", 32'(tot_rd[0] - r0), 32'h2);
      chk("busy_wr_count", 32'(tot_wr[0] - w0), 32'h2);

      // Misaligned sw/sh (rejected only with the alignment check built in), aligned-agnostic sb.
      rd_fixed = 32'h0BAD_F00D;
      issue(0, 2'b00, 32'h42);        wait_drain(0);
      issue(0, 2'b01, 32'h43);        wait_drain(0);
      issue(0, 2'b10, 32'h43);        wait_drain(0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
